// File: rtl/mem_responder.sv
// mem_responder: memory-mapped word array that answers a valid/ready request
// handshake after a fixed number of wait states.
//
// A request seen in IDLE is captured (address, strobes, data) and held for the
// whole access; later changes on the request inputs are ignored. The access
// then spends WAIT_CYCLES cycles in WAIT and one cycle in RESP, where
// mem_ready pulses. Dropping mem_valid during WAIT aborts the access silently.
//
// Parameters:
//   BASE_ADDR   byte address of word 0 of the array
//   MEM_WORDS   number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES wait states per access (0..15)
//
// Ports:
//   clk          sole clock, rising edge
//   resetn       asynchronous active-low reset
//   mem_valid    request strobe, held until mem_ready
//   mem_ready    one-cycle completion pulse
//   mem_wstrb    byte-lane write enables, 4'b0000 = read
//   mem_addr     34-bit physical byte address
//   mem_wdata    write data, lane i = bits [8i+7:8i]
//   mem_rdata    read data, held until the next completion
//   access_fault high with mem_ready when the access was rejected
module mem_responder #(
    parameter logic [33:0] BASE_ADDR   = 34'h0_8000_0000,
    parameter int unsigned MEM_WORDS   = 4096,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_wstrb,
    input  logic [33:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        access_fault
);

    localparam int unsigned IdxW      = $clog2(MEM_WORDS);
    localparam logic [3:0]  WaitInit  = 4'(WAIT_CYCLES);
    // One bit wider than the address so the end of the window cannot wrap.
    localparam logic [34:0] LimitAddr = {1'b0, BASE_ADDR} + (35'(MEM_WORDS) << 2);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [33:0]   addr_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   wdata_q;
    logic          fault_q;
    logic [31:0]   rdata_q;
    logic          capture;
    logic          load_resp;

    logic [31:0]   mem_q [MEM_WORDS];

    // Lookup path: on the accept edge (only relevant when WAIT_CYCLES=0) the
    // live request is decoded, otherwise the captured one.
    logic [33:0]   lk_addr;
    logic [3:0]    lk_wstrb;
    logic [IdxW+1:0] lk_word;
    logic [IdxW-1:0] lk_idx;
    logic          lk_in_range;
    logic          lk_fault;
    logic          unused_word_lsbs;

    always_comb begin
        lk_addr     = (state_q == StIdle) ? mem_addr : addr_q;
        lk_wstrb    = (state_q == StIdle) ? mem_wstrb : wstrb_q;
        lk_word     = lk_addr[IdxW+1:0] - BASE_ADDR[IdxW+1:0];
        lk_idx      = lk_word[IdxW+1:2];
        lk_in_range = ({1'b0, lk_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, lk_addr} < LimitAddr);
        // Partial-lane writes must be word aligned; full-word writes and reads
        // simply ignore the low address bits.
        lk_fault    = !lk_in_range ||
                      ((lk_addr[1:0] != 2'b00) && (lk_wstrb != 4'b0000) && (lk_wstrb != 4'b1111));
    end

    assign unused_word_lsbs = ^lk_word[1:0];

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        load_resp = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    capture = 1'b1;
                    cnt_d   = WaitInit;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = StResp;
                        load_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!mem_valid) begin
                    // Abort: no response, no write, read data untouched.
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d   = StResp;
                        load_resp = 1'b1;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q  <= mem_addr;
                wstrb_q <= mem_wstrb;
                wdata_q <= mem_wdata;
            end
            // Synchronous array read on the edge that enters RESP.
            if (load_resp) begin
                fault_q <= lk_fault;
                rdata_q <= lk_fault ? 32'h0 : mem_q[lk_idx];
            end
        end
    end

    // Array write on the edge that ends RESP; contents are never reset.
    always_ff @(posedge clk) begin
        if ((state_q == StResp) && !fault_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem_q[lk_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign mem_ready    = (state_q == StResp);
    assign access_fault = (state_q == StResp) && fault_q;
    assign mem_rdata    = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam logic [33:0] BASE = 34'h0_8000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;

    // dut0: default parameters (WAIT_CYCLES=2)
    logic        v0 = 1'b0, rdy0, f0;
    logic [3:0]  ws0 = '0;
    logic [33:0] a0 = '0;
    logic [31:0] wd0 = '0, rd0;
    // dut1: zero wait states
    logic        v1 = 1'b0, rdy1, f1;
    logic [3:0]  ws1 = '0;
    logic [33:0] a1 = '0;
    logic [31:0] wd1 = '0, rd1;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(4096), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .resetn(resetn), .mem_valid(v0), .mem_ready(rdy0), .mem_wstrb(ws0),
        .mem_addr(a0), .mem_wdata(wd0), .mem_rdata(rd0), .access_fault(f0)
    );

    mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(4096), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .resetn(resetn), .mem_valid(v1), .mem_ready(rdy1), .mem_wstrb(ws1),
        .mem_addr(a1), .mem_wdata(wd1), .mem_rdata(rd1), .access_fault(f1)
    );

    // One complete access on dut0. cyc = 1-based index of the cycle (counting
    // the cycle valid is first driven) in which ready is seen, 0 on timeout.
    task automatic access0(input logic [33:0] a, input logic [3:0] s, input logic [31:0] d,
                           output int cyc, output logic [31:0] rd, output logic flt,
                           output logic stray);
        cyc = 0; rd = '0; flt = 1'b0; stray = 1'b0;
        @(posedge clk); #1;
        v0 = 1'b1; a0 = a; ws0 = s; wd0 = d;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (rdy0) begin
                cyc = n; rd = rd0; flt = f0;
                break;
            end
            if (f0) stray = 1'b1;
        end
        @(posedge clk); #1;
        v0 = 1'b0; ws0 = '0;
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #10;
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %b want 0", rdy0); end
        checks++; if (f0 !== 1'b0) begin errors++; $display("FAIL reset_fault0 got %b want 0", f0); end
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0 got %h want 0", rd0); end
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %b want 0", rdy1); end
        checks++; if (f1 !== 1'b0) begin errors++; $display("FAIL reset_fault1 got %b want 0", f1); end
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1 got %h want 0", rd1); end
    endtask

    // Request already pending when reset releases: accepted on the first edge.
    task automatic test_first_accept();
        int n_seen;
        logic flt;
        n_seen = 0; flt = 1'b0;
        v0 = 1'b1; a0 = BASE; ws0 = 4'hF; wd0 = 32'h1111_1111;
        @(negedge clk);
        resetn = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (rdy0) begin n_seen = n; flt = f0; break; end
        end
        @(posedge clk); #1;
        v0 = 1'b0; ws0 = '0;
        checks++; if (n_seen !== 3) begin errors++; $display("FAIL first_accept_latency got %0d want 3", n_seen); end
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL first_accept_fault got %b want 0", flt); end
    endtask

    task automatic test_write_read();
        int cyc; logic [31:0] rd; logic flt, stray;
        access0(BASE + 34'h10, 4'hF, 32'hDEAD_BEEF, cyc, rd, flt, stray);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL wr_latency got %0d want 4", cyc); end
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL wr_fault got %b want 0", flt); end
        access0(BASE + 34'h10, 4'h0, 32'h0, cyc, rd, flt, stray);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL rd_latency got %0d want 4", cyc); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", rd); end
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL rd_fault got %b want 0", flt); end
        repeat (3) @(negedge clk);
        checks++; if (rd0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hold got %h want deadbeef", rd0); end
    endtask

    task automatic test_byte_write();
        int cyc; logic [31:0] rd; logic flt, stray;
        // Lane 2 (bits 23:16) carries 0xAA.
        access0(BASE + 34'h10, 4'b0100, 32'h00AA_0000, cyc, rd, flt, stray);
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL byte_wr_fault got %b want 0", flt); end
        access0(BASE + 34'h10, 4'h0, 32'h0, cyc, rd, flt, stray);
        checks++; if (rd !== 32'hDEAA_BEEF) begin errors++; $display("FAIL byte_rd got %h want deaabeef", rd); end
    endtask

    task automatic test_fault();
        int cyc; logic [31:0] rd; logic flt, stray;
        access0(34'h0_8000_4000, 4'h0, 32'h0, cyc, rd, flt, stray);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL oor_rd_latency got %0d want 4", cyc); end
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL oor_rd_fault got %b want 1", flt); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data got %h want 0", rd); end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL fault_without_ready got %b want 0", stray); end
        access0(34'h0_7FFF_FFFC, 4'hF, 32'hFFFF_FFFF, cyc, rd, flt, stray);
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL below_wr_fault got %b want 1", flt); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL below_wr_data got %h want 0", rd); end
        access0(BASE + 34'h11, 4'b0001, 32'h0000_00FF, cyc, rd, flt, stray);
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL misalign_fault got %b want 1", flt); end
        access0(BASE + 34'h3FFC, 4'h0, 32'h0, cyc, rd, flt, stray);
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL last_word_fault got %b want 0", flt); end
        access0(BASE + 34'h10, 4'h0, 32'h0, cyc, rd, flt, stray);
        checks++; if (rd !== 32'hDEAA_BEEF) begin errors++; $display("FAIL fault_unchanged got %h want deaabeef", rd); end
    endtask

    task automatic test_abort();
        int cyc; logic [31:0] rd; logic flt, stray; logic seen;
        access0(BASE, 4'h0, 32'h0, cyc, rd, flt, stray);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL abort_pre_rd got %h want 11111111", rd); end
        @(posedge clk); #1;
        v0 = 1'b1; a0 = BASE; ws0 = 4'hF; wd0 = 32'h1234_5678;
        @(posedge clk); #1;  // accepted; now in the first WAIT cycle
        v0 = 1'b0; ws0 = '0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rdy0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", seen); end
        checks++; if (rd0 !== 32'h1111_1111) begin errors++; $display("FAIL abort_rdata got %h want 11111111", rd0); end
        access0(BASE, 4'h0, 32'h0, cyc, rd, flt, stray);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL abort_post_rd got %h want 11111111", rd); end
    endtask

    task automatic test_ignore_changes();
        int cyc; logic [31:0] rd; logic flt, stray; logic seen;
        @(posedge clk); #1;
        v0 = 1'b1; a0 = BASE + 34'h20; ws0 = 4'hF; wd0 = 32'h0BAD_F00D;
        @(posedge clk); #1;
        a0 = BASE + 34'h24; ws0 = 4'b0001; wd0 = 32'hFFFF_FFFF;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rdy0) begin seen = 1'b1; break; end
        end
        @(posedge clk); #1;
        v0 = 1'b0; ws0 = '0;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ignore_ready got %b want 1", seen); end
        access0(BASE + 34'h20, 4'h0, 32'h0, cyc, rd, flt, stray);
        checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL ignore_data got %h want 0badf00d", rd); end
    endtask

    task automatic test_reset_mid();
        int cyc; logic [31:0] rd; logic flt, stray; logic seen;
        // Reset while in WAIT of a write.
        @(posedge clk); #1;
        v0 = 1'b1; a0 = BASE + 34'h10; ws0 = 4'hF; wd0 = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL rst_wait_ready got %b want 0", rdy0); end
        checks++; if (f0 !== 1'b0) begin errors++; $display("FAIL rst_wait_fault got %b want 0", f0); end
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL rst_wait_rdata got %h want 0", rd0); end
        v0 = 1'b0; ws0 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        // Reset while in RESP of a write.
        @(posedge clk); #1;
        v0 = 1'b1; a0 = BASE + 34'h10; ws0 = 4'hF; wd0 = 32'h5555_5555;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rdy0) begin seen = 1'b1; break; end
        end
        resetn = 1'b0;
        #1;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_resp_reached got %b want 1", seen); end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL rst_resp_ready got %b want 0", rdy0); end
        v0 = 1'b0; ws0 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        access0(BASE + 34'h10, 4'h0, 32'h0, cyc, rd, flt, stray);
        checks++; if (rd !== 32'hDEAA_BEEF) begin errors++; $display("FAIL rst_unchanged got %h want deaabeef", rd); end
    endtask

    // dut1: 8 back-to-back writes then 8 back-to-back reads, valid held high.
    task automatic set_req1(input int j);
        if (j < 8) begin
            a1 = BASE + 34'(4 * j); ws1 = 4'hF; wd1 = 32'hA500_0000 + 32'(j);
        end else begin
            a1 = BASE + 34'(4 * (j - 8)); ws1 = 4'h0; wd1 = 32'h0;
        end
    endtask

    task automatic test_back_to_back();
        int last, t; logic got;
        last = 0;
        @(posedge clk); #1;
        v1 = 1'b1; set_req1(0);
        for (int i = 0; i < 16; i++) begin
            got = 1'b0;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                if (rdy1) begin got = 1'b1; break; end
            end
            t = cycle;
            checks++; if (got !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, got); end
            checks++; if (f1 !== 1'b0) begin errors++; $display("FAIL b2b_fault[%0d] got %b want 0", i, f1); end
            if (i >= 8) begin
                checks++;
                if (rd1 !== 32'hA500_0000 + 32'(i - 8)) begin
                    errors++;
                    $display("FAIL b2b_data[%0d] got %h want %h", i - 8, rd1, 32'hA500_0000 + 32'(i - 8));
                end
            end
            if (i > 0) begin
                checks++; if (t - last !== 2) begin errors++; $display("FAIL b2b_period[%0d] got %0d want 2", i, t - last); end
            end
            last = t;
            @(posedge clk); #1;
            if (i < 15) set_req1(i + 1);
            else begin v1 = 1'b0; ws1 = '0; end
        end
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_write_read();
        test_byte_write();
        test_fault();
        test_abort();
        test_ignore_changes();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
